// File: rtl/adc_serial_reg_writer_if.sv
// Request/serial-bus bundle for adc_serial_reg_writer.
// master: upstream requester (drives requests, observes serial lines and status).
// slave : the register writer itself.
interface adc_serial_reg_writer_if;
  logic init;
  logic des_enable;
  logic des_disable;
  logic sclk;
  logic sdata;
  logic select;
  logic done;
  logic busy;

  modport master (
    output init, des_enable, des_disable,
    input  sclk, sdata, select, done, busy
  );

  modport slave (
    input  init, des_enable, des_disable,
    output sclk, sdata, select, done, busy
  );
endinterface

// File: rtl/adc_serial_reg_writer.sv
// Three-wire serial register writer for the ADC extended-control interface.
// Shifts fixed 32-bit frames ({12'h001, addr[3:0], data[15:0]}, MSB first)
// out on sclk/sdata/select in response to level requests, then pulses done.
// Optional build macro ADC_SER_TESTPAT_EN appends a fifth init frame
// (0x1, 0xB3FF) that turns on the ADC test-pattern output.
module adc_serial_reg_writer #(
  parameter int unsigned CLK_DIV    = 4,
  parameter int unsigned GAP_CYCLES = 16
) (
  input  logic                   Clock,
  input  logic                   Reset,
  adc_serial_reg_writer_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    SHIFT,
    HOLD,
    GAP,
    RELEASE
  } state_t;

  localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);
  localparam logic [7:0] GAP_LAST = 8'(GAP_CYCLES - 1);

  // Frame ROM layout: 0..3 (or 0..4) init sequence, then the two DES frames.
  localparam logic [2:0] INIT_FIRST  = 3'd0;
`ifdef ADC_SER_TESTPAT_EN
  localparam logic [2:0] INIT_LAST   = 3'd4;
`else
  localparam logic [2:0] INIT_LAST   = 3'd3;
`endif
  localparam logic [2:0] DES_ON_IDX  = 3'd5;
  localparam logic [2:0] DES_OFF_IDX = 3'd6;

  function automatic logic [31:0] frame_word(input logic [2:0] idx);
    logic [3:0]  addr;
    logic [15:0] data;
    case (idx)
      3'd0:    begin addr = 4'h1; data = 16'hB2FF; end
      3'd1:    begin addr = 4'h2; data = 16'h007F; end
      3'd2:    begin addr = 4'h3; data = 16'h807F; end
      3'd3:    begin addr = 4'hD; data = 16'h3FFF; end
      3'd4:    begin addr = 4'h1; data = 16'hB3FF; end
      3'd5:    begin addr = 4'hE; data = 16'hBFFF; end
      3'd6:    begin addr = 4'hE; data = 16'h3FFF; end
      default: begin addr = 4'h0; data = 16'h0000; end
    endcase
    return {12'h001, addr, data};
  endfunction

  state_t      state_q, state_d;
  logic [7:0]  div_q, div_d;
  logic [5:0]  bit_q, bit_d;
  logic        half_q, half_d;
  logic [2:0]  ptr_q, ptr_d;
  logic [2:0]  last_q, last_d;
  logic        sclk_q, sclk_d;
  logic        sdata_q, sdata_d;
  logic        select_q, select_d;
  logic        done_q, done_d;
  logic        busy_q, busy_d;
  logic [31:0] frame_d;
  logic        shifting_d;

  // Next-state sequencing; outputs are derived from the next state so that
  // every serial line and status flag comes straight off a register.
  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    bit_d   = bit_q;
    half_d  = half_q;
    ptr_d   = ptr_q;
    last_d  = last_q;
    done_d  = 1'b0;

    case (state_q)
      IDLE: begin
        div_d  = '0;
        bit_d  = '0;
        half_d = 1'b0;
        if (bus.init) begin
          state_d = SETUP;
          ptr_d   = INIT_FIRST;
          last_d  = INIT_LAST;
        end else if (bus.des_disable) begin
          state_d = SETUP;
          ptr_d   = DES_OFF_IDX;
          last_d  = DES_OFF_IDX;
        end else if (bus.des_enable) begin
          state_d = SETUP;
          ptr_d   = DES_ON_IDX;
          last_d  = DES_ON_IDX;
        end
      end
      SETUP: begin
        if (div_q == DIV_LAST) begin
          state_d = SHIFT;
          div_d   = '0;
          half_d  = 1'b0;
        end else begin
          div_d = div_q + 8'd1;
        end
      end
      SHIFT: begin
        if (div_q == DIV_LAST) begin
          div_d = '0;
          if (!half_q) begin
            half_d = 1'b1;
          end else if (bit_q == 6'd31) begin
            state_d = HOLD;
            half_d  = 1'b0;
          end else begin
            bit_d  = bit_q + 6'd1;
            half_d = 1'b0;
          end
        end else begin
          div_d = div_q + 8'd1;
        end
      end
      HOLD: begin
        if (div_q == DIV_LAST) begin
          state_d = GAP;
          div_d   = '0;
        end else begin
          div_d = div_q + 8'd1;
        end
      end
      GAP: begin
        // After the final gap, GAP is extended by one cycle carrying done,
        // so busy stays high through the done pulse.
        if (done_q) begin
          state_d = RELEASE;
        end else if (div_q == GAP_LAST) begin
          if (ptr_q != last_q) begin
            state_d = SETUP;
            ptr_d   = ptr_q + 3'd1;
            div_d   = '0;
            bit_d   = '0;
            half_d  = 1'b0;
          end else begin
            done_d = 1'b1;
          end
        end else begin
          div_d = div_q + 8'd1;
        end
      end
      RELEASE: begin
        if (!(bus.init || bus.des_enable || bus.des_disable)) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    frame_d    = frame_word(ptr_d);
    shifting_d = (state_d == SETUP) || (state_d == SHIFT) || (state_d == HOLD);
    select_d   = !shifting_d;
    sclk_d     = (state_d == SHIFT) && half_d;
    sdata_d    = shifting_d ? frame_d[5'd31 - bit_d[4:0]] : 1'b0;
    busy_d     = shifting_d || (state_d == GAP);
  end

  // State, counters and registered outputs; reset abandons any partial frame.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q  <= IDLE;
      div_q    <= '0;
      bit_q    <= '0;
      half_q   <= 1'b0;
      ptr_q    <= '0;
      last_q   <= '0;
      sclk_q   <= 1'b0;
      sdata_q  <= 1'b0;
      select_q <= 1'b1;
      done_q   <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      div_q    <= div_d;
      bit_q    <= bit_d;
      half_q   <= half_d;
      ptr_q    <= ptr_d;
      last_q   <= last_d;
      sclk_q   <= sclk_d;
      sdata_q  <= sdata_d;
      select_q <= select_d;
      done_q   <= done_d;
      busy_q   <= busy_d;
    end
  end

  assign bus.sclk   = sclk_q;
  assign bus.sdata  = sdata_q;
  assign bus.select = select_q;
  assign bus.done   = done_q;
  assign bus.busy   = busy_q;

endmodule

// File: tb/tb_adc_serial_reg_writer.sv
// Self-checking bench for adc_serial_reg_writer: frames are decoded off
// sclk rising edges and compared with the frame list and timing formula.
module tb_adc_serial_reg_writer;

  localparam int unsigned CLK_DIV    = 4;
  localparam int unsigned GAP_CYCLES = 16;
  localparam int FRAME_CYC = 66 * CLK_DIV + GAP_CYCLES;
  localparam int LONG_HOLD = 5 * FRAME_CYC + 40;

  logic Clock = 1'b0;
  logic Reset = 1'b1;

  adc_serial_reg_writer_if bus_if();

  adc_serial_reg_writer #(
    .CLK_DIV    (CLK_DIV),
    .GAP_CYCLES (GAP_CYCLES)
  ) dut (
    .Clock (Clock),
    .Reset (Reset),
    .bus   (bus_if)
  );

  always #5 Clock = ~Clock;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  always @(posedge Clock) cyc <= cyc + 1;

  // Serial-line decoder, sampled on the falling clock edge.
  logic        prev_sclk = 1'b0;
  logic        prev_sel  = 1'b1;
  logic [31:0] shreg     = '0;
  int          nbits     = 0;
  int          sel_low   = 0;
  logic [31:0] got_frames[$];
  int          got_bits[$];
  int          got_low[$];
  int          done_cycles[$];
  int          busy_cnt   = 0;
  int          busy_first = -1;
  logic [31:0] exp_frames[$];

  always @(negedge Clock) begin
    if (!bus_if.select) begin
      if (prev_sel) begin
        shreg   = '0;
        nbits   = 0;
        sel_low = 0;
      end
      sel_low++;
      if (bus_if.sclk && !prev_sclk) begin
        shreg = {shreg[30:0], bus_if.sdata};
        nbits++;
      end
    end else if (!prev_sel) begin
      got_frames.push_back(shreg);
      got_bits.push_back(nbits);
      got_low.push_back(sel_low);
    end
    if (bus_if.done) done_cycles.push_back(cyc);
    if (bus_if.busy) begin
      busy_cnt++;
      if (busy_first < 0) busy_first = cyc;
    end
    prev_sclk = bus_if.sclk;
    prev_sel  = bus_if.select;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_mon();
    got_frames.delete();
    got_bits.delete();
    got_low.delete();
    done_cycles.delete();
    busy_cnt   = 0;
    busy_first = -1;
  endtask

  // Reference frame list: kind 0 = init, 1 = DES-off, 2 = DES-on.
  task automatic build_expected(input int kind);
    logic [3:0]  a[$];
    logic [15:0] d[$];
    exp_frames.delete();
    case (kind)
      0: begin
        a = '{4'h1, 4'h2, 4'h3, 4'hD};
        d = '{16'hB2FF, 16'h007F, 16'h807F, 16'h3FFF};
`ifdef ADC_SER_TESTPAT_EN
        a.push_back(4'h1);
        d.push_back(16'hB3FF);
`endif
      end
      1: begin
        a = '{4'hE};
        d = '{16'h3FFF};
      end
      default: begin
        a = '{4'hE};
        d = '{16'hBFFF};
      end
    endcase
    foreach (a[i]) exp_frames.push_back({12'h001, a[i], d[i]});
  endtask

  task automatic drive_req(input logic i, input logic dd, input logic de);
    bus_if.init        = i;
    bus_if.des_disable = dd;
    bus_if.des_enable  = de;
  endtask

  // One request: kind is the highest-priority line raised, extra[1]/[0] add
  // des_disable/des_enable alongside it (only when lower priority).
  task automatic run_seq(input int kind, input int hold, input logic [1:0] extra_in);
    int         cyc0;
    int         n;
    int         exp_done;
    int         limit;
    logic [1:0] extra;
    string      nm;
    extra = extra_in;
    if (kind == 1) extra[1] = 1'b0;
    if (kind == 2) extra = '0;
    build_expected(kind);
    n        = exp_frames.size();
    exp_done = n * FRAME_CYC + 1;
    limit    = ((hold > exp_done) ? hold : exp_done) + 20;
    nm       = $sformatf("k%0d_h%0d", kind, hold);

    @(negedge Clock);
    clear_mon();
    drive_req(kind == 0, (kind == 1) || extra[1], (kind == 2) || extra[0]);
    cyc0 = cyc;
    for (int rel = 1; rel <= limit; rel++) begin
      @(negedge Clock);
      if (rel >= hold) begin
        drive_req(1'b0, 1'b0, 1'b0);
      end else if ($urandom_range(0, 3) == 0) begin
        // Toggle non-primary lines mid-sequence; they must be ignored.
        if (kind != 0) bus_if.init        = 1'($urandom_range(0, 1));
        if (kind != 1) bus_if.des_disable = 1'($urandom_range(0, 1));
        if (kind != 2) bus_if.des_enable  = 1'($urandom_range(0, 1));
      end
    end
    drive_req(1'b0, 1'b0, 1'b0);

    check({nm, "_done_count"}, done_cycles.size(), 1);
    if (done_cycles.size() > 0) check({nm, "_done_cycle"}, done_cycles[0] - cyc0, exp_done);
    check({nm, "_busy_first"}, busy_first - cyc0, 1);
    check({nm, "_busy_cycles"}, busy_cnt, exp_done);
    check({nm, "_frame_count"}, got_frames.size(), n);
    for (int i = 0; i < n && i < got_frames.size(); i++) begin
      check($sformatf("%s_frame%0d", nm, i), got_frames[i], exp_frames[i]);
      check($sformatf("%s_bits%0d", nm, i), got_bits[i], 32);
      check($sformatf("%s_sel_low%0d", nm, i), got_low[i], 66 * CLK_DIV);
    end
    repeat (3) @(negedge Clock);
  endtask

  initial begin
    int tgt;
    int cyc0;
    int kind;
    int hold;
    drive_req(1'b0, 1'b0, 1'b0);
    Reset = 1'b1;
    repeat (3) @(negedge Clock);
    check("rst_sclk",   bus_if.sclk,   1'b0);
    check("rst_sdata",  bus_if.sdata,  1'b0);
    check("rst_select", bus_if.select, 1'b1);
    check("rst_done",   bus_if.done,   1'b0);
    check("rst_busy",   bus_if.busy,   1'b0);
    Reset = 1'b0;
    repeat (2) @(negedge Clock);

    // Init held well past done: exactly one sequence.
    run_seq(0, LONG_HOLD, 2'b00);
    // Single-cycle DES-on pulse.
    run_seq(2, 1, 2'b00);
    // Init and des_disable together, both held: init only, no retrigger.
    run_seq(0, LONG_HOLD, 2'b10);
    // des_disable re-raised after everything dropped.
    run_seq(1, 1, 2'b00);

    // Reset during bit 10 of frame 2.
    build_expected(0);
    @(negedge Clock);
    clear_mon();
    drive_req(1'b1, 1'b0, 1'b0);
    cyc0 = cyc;
    tgt  = FRAME_CYC + CLK_DIV + 20 * CLK_DIV + $urandom_range(1, 2 * CLK_DIV);
    for (int rel = 1; rel < tgt; rel++) begin
      @(negedge Clock);
      if (rel == 2) bus_if.init = 1'b0;
    end
    @(negedge Clock);
    check("pre_reset_select", bus_if.select, 1'b0);
    Reset = 1'b1;
    @(negedge Clock);
    check("mid_rst_select", bus_if.select, 1'b1);
    check("mid_rst_sclk",   bus_if.sclk,   1'b0);
    check("mid_rst_sdata",  bus_if.sdata,  1'b0);
    check("mid_rst_busy",   bus_if.busy,   1'b0);
    check("mid_rst_done",   bus_if.done,   1'b0);
    @(negedge Clock);
    Reset = 1'b0;
    repeat (FRAME_CYC + 20) @(negedge Clock);
    check("mid_rst_no_done", done_cycles.size(), 0);
    check("mid_rst_frame1", got_frames[0], exp_frames[0]);
    check("mid_rst_idle_sel", bus_if.select, 1'b1);
    // Fresh init must restart from frame 1.
    run_seq(0, 1, 2'b00);

    // Randomized requests.
    for (int k = 0; k < 5; k++) begin
      kind = $urandom_range(0, 2);
      case ($urandom_range(0, 2))
        0:       hold = 1;
        1:       hold = $urandom_range(2, 100);
        default: hold = 5 * FRAME_CYC + $urandom_range(10, 60);
      endcase
      run_seq(kind, hold, 2'($urandom_range(0, 3)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/adc_serial_reg_writer.md
Name: adc_serial_reg_writer

Overview:
- Three-wire serial register writer for the ADC extended-control interface; sits directly downstream of the ADC power/calibration state machine.
- Accepts level requests (init, des_enable, des_disable) and shifts fixed 32-bit register frames out on sclk/sdata/select.
- Pulses done once the whole requested sequence has been written.
- Its outputs are tri-stated by the parent, so this block always drives defined levels.

Parameters:
- CLK_DIV, 4: Clock cycles per sclk half-period (legal 2..255).
- GAP_CYCLES, 16: Clock cycles select is held high between frames and after the last frame (legal 1..255).

Ports:
- Clock  in  1  system clock
- Reset  in  1  synchronous, active-high
- init  in  1  level request: write the init sequence
- des_enable  in  1  level request: write DES-on frame
- des_disable  in  1  level request: write DES-off frame
- sclk  out  1  serial clock to ADC, idle low
- sdata  out  1  serial data, MSB first
- select  out  1  frame select, active low
- done  out  1  one-cycle pulse, sequence complete
- busy  out  1  high from request acceptance until done pulse inclusive

Behaviour:
- Reset values: sclk=0, sdata=0, select=1, done=0, busy=0; state IDLE.
- Frame format, 32 bits MSB first: 12'b0000_0000_0001 header, 4-bit address, 16-bit data.
- Init sequence (addr, data):
  - (0x1, 0xB2FF)
  - (0x2, 0x007F)
  - (0x3, 0x807F)
  - (0xD, 0x3FFF)
- DES-on: single frame (0xE, 0xBFFF). DES-off: single frame (0xE, 0x3FFF).
- States: IDLE, SETUP, SHIFT, HOLD, GAP, RELEASE.
- IDLE: evaluates requests every cycle. Priority is init > des_disable > des_enable. Accepting a request loads the sequence pointer and sets busy the next cycle.
- SETUP: select=0, sclk=0, sdata = bit 31 of frame; lasts CLK_DIV cycles.
- SHIFT: 32 bit periods, each 2*CLK_DIV cycles.
  - sclk low for the first half, high for the second.
  - sdata changes only at the start of a low half, so the ADC samples on the sclk rising edge.
  - A 6-bit bit counter plus a CLK_DIV-wide divider counter control timing.
- HOLD: sclk=0, select=0, data stable, for CLK_DIV cycles. Then select=1 and sdata=0.
- GAP: select=1 for GAP_CYCLES.
  - If more frames remain, go to SETUP with the next ROM entry.
  - Otherwise assert done for exactly one cycle, then go to RELEASE.
- Frame length: 66*CLK_DIV cycles with select low (264 at default), plus GAP_CYCLES.
- Timing: done is high in cycle N*(66*CLK_DIV+GAP_CYCLES)+1 after the accepting edge, where N is the frame count (1120+1 at defaults for init, 280+1 for DES frames).
- RELEASE: busy=0. Waits until init, des_enable and des_disable are all low, then goes to IDLE. A held request must never retrigger.
- Requests changing mid-sequence are ignored; the sequence in progress always completes.
- Reset mid-frame: outputs return to reset values the next cycle, no done is generated, and the partial frame is abandoned.
- sclk, sdata, select and done are all registered; no combinational path from inputs to outputs.

Optional Feature:
- ADC_SER_TESTPAT_EN defined: the init sequence gains a fifth frame (0x1, 0xB3FF), enabling the ADC test-pattern output. Init done then arrives at 5*(66*CLK_DIV+GAP_CYCLES)+1 cycles (1401 at defaults).
- Not defined: the init sequence is exactly the four frames above.
- DES frames are unaffected either way.

Test Plan:
- Reset then init held high -> four frames decoded off sclk rising edges equal 0x0011B2FF, 0x0012007F, 0x0013807F, 0x001D3FFF; one done pulse at cycle 1121; no second sequence while init stays high.
- des_enable pulsed for 1 cycle -> single frame 0x001EBFFF; select low for exactly 264 cycles; done pulse at cycle 281; busy high cycles 1..281.
- init and des_disable asserted in the same cycle -> init sequence runs first. des_disable still high after release -> 0x001E3FFF sent only after all requests drop and re-rise.
- Reset asserted during bit 10 of frame 2 -> next cycle select=1, sclk=0, sdata=0, done never pulses. A subsequent init restarts from frame 1.
- CLK_DIV=2, GAP_CYCLES=1 -> sclk period 4 cycles; DES-off done at cycle 134.
- ADC_SER_TESTPAT_EN defined -> fifth frame 0x0011B3FF; done at cycle 1401.
